// File: rtl/l3_fill_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : l3_fill_responder
// Description : Direct-mapped, one-word-per-line L3 responder for L2 misses.
//               A request is registered in IDLE, looked up in LOOKUP, filled
//               from main memory in MEM_WAIT on a miss, and answered from
//               RESPOND. Writes merge the selected low bytes into the line and
//               are written through to memory in the same cycle as the
//               response strobe.
//
//               Response timing: the response strobe, returned data and
//               write-through strobe are registered on the edge that leaves
//               RESPOND. A hit therefore answers 2 cycles after the acceptance
//               edge, and a miss answers 1 cycle after mem_rd_valid_i is sampled.
//
// Ports       : clk, rst (sync, active-low)
//               l2_req_i / l3_ready_o            request handshake
//               addr_i, wr_en_i, wr_data_i,
//               byte_en_i                        request payload
//               l3_cache_valid_o, l3_cache_data_o response to L2
//               mem_rd_en_o, mem_wr_en_o,
//               mem_addr_o, mem_wr_data_o        main-memory request side
//               mem_rd_valid_i, mem_rd_data_i    main-memory read return
//               hit_count_o, miss_count_o        statistics
//
// Config      : L3_FILL_STATS_EN - when defined, hit/miss counters are built
//               (saturating); otherwise both counter outputs are tied to 0.
//
// Revision    : 1.0 - initial release
// ============================================================================
module l3_fill_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_LINES  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  l2_req_i,
    output logic                  l3_ready_o,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [3:0]            byte_en_i,
    output logic                  l3_cache_valid_o,
    output logic [DATA_WIDTH-1:0] l3_cache_data_o,
    output logic                  mem_rd_en_o,
    output logic                  mem_wr_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wr_data_o,
    input  logic                  mem_rd_valid_i,
    input  logic [DATA_WIDTH-1:0] mem_rd_data_i,
    output logic [31:0]           hit_count_o,
    output logic [31:0]           miss_count_o
);

    localparam int c_INDEX_W = $clog2(NUM_LINES);
    localparam int c_WORD_W  = ADDR_WIDTH - 2;
    localparam int c_TAG_W   = c_WORD_W - c_INDEX_W;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOOKUP   = 2'd1,
        MEM_WAIT = 2'd2,
        RESPOND  = 2'd3
    } state_t;

    state_t                  state_q, state_d;

    // Line storage: valid bits need reset, tag/data arrays do not.
    logic [NUM_LINES-1:0]    line_valid_q;
    logic [c_TAG_W-1:0]      line_tag_q  [NUM_LINES];
    logic [DATA_WIDTH-1:0]   line_data_q [NUM_LINES];

    // Registered request
    logic [c_WORD_W-1:0]     word_addr_q;
    logic                    wr_en_q;
    logic [DATA_WIDTH-1:0]   wr_data_q;
    logic [3:0]              byte_en_q;

    // Registered outputs
    logic                    resp_valid_q;
    logic [DATA_WIDTH-1:0]   resp_data_q;
    logic                    mem_rd_en_q;
    logic                    mem_wr_en_q;
    logic [DATA_WIDTH-1:0]   mem_wr_data_q;

    logic [c_INDEX_W-1:0]    w_index;
    logic [c_TAG_W-1:0]      w_tag;
    logic                    w_hit;
    logic                    w_accept;
    logic                    w_fill;
    logic                    w_be_legal;
    logic                    w_do_write;
    logic [DATA_WIDTH-1:0]   w_line_word;
    logic [DATA_WIDTH-1:0]   w_mask;
    logic [DATA_WIDTH-1:0]   w_merged;
    logic                    w_unused_addr;

    // The byte offset never participates in lookup or memory addressing.
    assign w_unused_addr = ^addr_i[1:0];

    assign w_index     = word_addr_q[c_INDEX_W-1:0];
    assign w_tag       = word_addr_q[c_WORD_W-1:c_INDEX_W];
    assign w_line_word = line_data_q[w_index];
    assign w_hit       = line_valid_q[w_index] && (line_tag_q[w_index] == w_tag);
    assign w_accept    = l2_req_i && (state_q == IDLE);
    assign w_fill      = (state_q == MEM_WAIT) && mem_rd_valid_i;
    assign w_be_legal  = (byte_en_q == 4'b0001) || (byte_en_q == 4'b0011) ||
                         (byte_en_q == 4'b1111);
    assign w_do_write  = (state_q == RESPOND) && wr_en_q && w_be_legal;

    always_comb begin
        w_mask = '0;
        case (byte_en_q)
            4'b0001: w_mask[7:0]  = '1;
            4'b0011: w_mask[15:0] = '1;
            4'b1111: w_mask       = '1;
            default: w_mask       = '0;
        endcase
    end

    assign w_merged = (w_line_word & ~w_mask) | (wr_data_q & w_mask);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (w_accept) state_d = LOOKUP;
            LOOKUP:   state_d = w_hit ? RESPOND : MEM_WAIT;
            MEM_WAIT: if (mem_rd_valid_i) state_d = RESPOND;
            RESPOND:  state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            line_valid_q  <= '0;
            word_addr_q   <= '0;
            wr_en_q       <= 1'b0;
            wr_data_q     <= '0;
            byte_en_q     <= '0;
            resp_valid_q  <= 1'b0;
            resp_data_q   <= '0;
            mem_rd_en_q   <= 1'b0;
            mem_wr_en_q   <= 1'b0;
            mem_wr_data_q <= '0;
        end else begin
            state_q <= state_d;

            if (w_accept) begin
                word_addr_q <= addr_i[ADDR_WIDTH-1:2];
                wr_en_q     <= wr_en_i;
                wr_data_q   <= wr_data_i;
                byte_en_q   <= byte_en_i;
            end

            if (w_fill) begin
                line_valid_q[w_index] <= 1'b1;
            end

            // Read strobe covers only the first MEM_WAIT cycle.
            mem_rd_en_q   <= (state_q == LOOKUP) && !w_hit;

            // Response carries the pre-merge line word; zero otherwise.
            resp_valid_q  <= (state_q == RESPOND);
            resp_data_q   <= (state_q == RESPOND) ? w_line_word : '0;
            mem_wr_en_q   <= w_do_write;
            mem_wr_data_q <= w_do_write ? w_merged : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if (w_fill) begin
                line_tag_q[w_index]  <= w_tag;
                line_data_q[w_index] <= mem_rd_data_i;
            end else if (w_do_write) begin
                line_data_q[w_index] <= w_merged;
            end
        end
    end

`ifdef L3_FILL_STATS_EN
    logic [31:0] hit_count_q;
    logic [31:0] miss_count_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else if (state_q == LOOKUP) begin
            if (w_hit) begin
                if (hit_count_q != 32'hFFFF_FFFF) hit_count_q <= hit_count_q + 32'd1;
            end else begin
                if (miss_count_q != 32'hFFFF_FFFF) miss_count_q <= miss_count_q + 32'd1;
            end
        end
    end

    assign hit_count_o  = hit_count_q;
    assign miss_count_o = miss_count_q;
`else
    assign hit_count_o  = 32'd0;
    assign miss_count_o = 32'd0;
`endif

    assign l3_ready_o       = (state_q == IDLE);
    assign l3_cache_valid_o = resp_valid_q;
    assign l3_cache_data_o  = resp_data_q;
    assign mem_rd_en_o      = mem_rd_en_q;
    assign mem_wr_en_o      = mem_wr_en_q;
    assign mem_wr_data_o    = mem_wr_data_q;
    assign mem_addr_o       = {word_addr_q, 2'b00};

endmodule
`default_nettype wire

// File: tb/tb_l3_fill_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_l3_fill_responder
// Description : Self-checking bench for l3_fill_responder. A table of directed
//               request records is applied in order; a small memory responder
//               returns fill data after a per-record delay. Hand-written
//               sequences cover a request held during a miss and a reset
//               taken in MEM_WAIT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l3_fill_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        l2_req_i;
    logic        l3_ready_o;
    logic [31:0] addr_i;
    logic        wr_en_i;
    logic [31:0] wr_data_i;
    logic [3:0]  byte_en_i;
    logic        l3_cache_valid_o;
    logic [31:0] l3_cache_data_o;
    logic        mem_rd_en_o;
    logic        mem_wr_en_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wr_data_o;
    logic        mem_rd_valid_i;
    logic [31:0] mem_rd_data_i;
    logic [31:0] hit_count_o;
    logic [31:0] miss_count_o;

    always #5 clk = ~clk;

    l3_fill_responder dut (
        .clk              (clk),
        .rst              (rst),
        .l2_req_i         (l2_req_i),
        .l3_ready_o       (l3_ready_o),
        .addr_i           (addr_i),
        .wr_en_i          (wr_en_i),
        .wr_data_i        (wr_data_i),
        .byte_en_i        (byte_en_i),
        .l3_cache_valid_o (l3_cache_valid_o),
        .l3_cache_data_o  (l3_cache_data_o),
        .mem_rd_en_o      (mem_rd_en_o),
        .mem_wr_en_o      (mem_wr_en_o),
        .mem_addr_o       (mem_addr_o),
        .mem_wr_data_o    (mem_wr_data_o),
        .mem_rd_valid_i   (mem_rd_valid_i),
        .mem_rd_data_i    (mem_rd_data_i),
        .hit_count_o      (hit_count_o),
        .miss_count_o     (miss_count_o)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        hit;
        logic [31:0] mem_data;
        logic [3:0]  lat;
        logic [31:0] exp_data;
        logic        exp_wr;
        logic [31:0] exp_wdata;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;
    int exp_hits = 0;
    int exp_misses = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_counts(input string name);
        logic [31:0] eh, em;
`ifdef L3_FILL_STATS_EN
        eh = exp_hits;
        em = exp_misses;
`else
        eh = 32'd0;
        em = 32'd0;
`endif
        chk({name, " hit_count"},  hit_count_o,  eh);
        chk({name, " miss_count"}, miss_count_o, em);
    endtask

    task automatic do_txn(input vec_t v, input string name);
        int rd_k, ret_k, resp_k, rd_pulses, exp_k;
        logic returned, wen;
        logic [31:0] rdata, wdata, maddr;
        rd_k = -1; ret_k = -1; resp_k = -1; rd_pulses = 0; returned = 1'b0;
        wen = 1'b0; rdata = '0; wdata = '0; maddr = '0;

        chk({name, " ready"}, {31'd0, l3_ready_o}, 32'd1);
        l2_req_i  = 1'b1;
        addr_i    = v.addr;
        wr_en_i   = v.wr;
        wr_data_i = v.wdata;
        byte_en_i = v.be;
        step();
        l2_req_i = 1'b0;

        for (int k = 1; k <= 40; k++) begin
            step();
            if (mem_rd_valid_i) begin
                mem_rd_valid_i = 1'b0;
                mem_rd_data_i  = '0;
                ret_k = k;
            end
            if (mem_rd_en_o) begin
                rd_pulses++;
                if (rd_k < 0) rd_k = k;
            end
            if (rd_k >= 0 && !returned && k >= rd_k + int'(v.lat)) begin
                mem_rd_valid_i = 1'b1;
                mem_rd_data_i  = v.mem_data;
                returned = 1'b1;
            end
            if (l3_cache_valid_o) begin
                resp_k = k;
                rdata  = l3_cache_data_o;
                wen    = mem_wr_en_o;
                wdata  = mem_wr_data_o;
                maddr  = mem_addr_o;
                break;
            end
        end
        mem_rd_valid_i = 1'b0;

        exp_k = v.hit ? 2 : ret_k + 1;
        chk({name, " latency"}, resp_k, exp_k);
        chk({name, " rd pulses"}, rd_pulses, v.hit ? 32'd0 : 32'd1);
        if (!v.hit) chk({name, " rd strobe cycle"}, rd_k, 32'd1);
        chk({name, " data"}, rdata, v.exp_data);
        chk({name, " mem_wr_en"}, {31'd0, wen}, {31'd0, v.exp_wr});
        if (v.exp_wr) chk({name, " mem_wr_data"}, wdata, v.exp_wdata);
        chk({name, " mem_addr"}, maddr, {v.addr[31:2], 2'b00});

        if (v.hit) exp_hits++; else exp_misses++;
        chk_counts(name);

        step();
        chk({name, " valid drop"}, {31'd0, l3_cache_valid_o}, 32'd0);
        chk({name, " data zero"}, l3_cache_data_o, 32'd0);
        chk({name, " wr drop"}, {31'd0, mem_wr_en_o}, 32'd0);
    endtask

    vec_t vecs[17];
    vec_t post[2];

    initial begin
        int nvalid, nrd, nwr;

        //              addr          wr    wdata         be     hit   mem_data      lat   exp_data      exp_wr exp_wdata
        vecs[0]  = '{32'h0000_1000, 1'b0, 32'h0,        4'hF, 1'b0, 32'hDEAD_BEEF, 4'd1, 32'hDEAD_BEEF, 1'b0, 32'h0};
        vecs[1]  = '{32'h0000_1000, 1'b0, 32'h0,        4'hF, 1'b1, 32'h0,        4'd0, 32'hDEAD_BEEF, 1'b0, 32'h0};
        vecs[2]  = '{32'h0000_1000, 1'b1, 32'h0000_0055, 4'h1, 1'b1, 32'h0,        4'd0, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BE55};
        vecs[3]  = '{32'h0000_1000, 1'b0, 32'h0,        4'hF, 1'b1, 32'h0,        4'd0, 32'hDEAD_BE55, 1'b0, 32'h0};
        vecs[4]  = '{32'h0000_1000, 1'b1, 32'h1234_5678, 4'h3, 1'b1, 32'h0,        4'd0, 32'hDEAD_BE55, 1'b1, 32'hDEAD_5678};
        vecs[5]  = '{32'h0000_1003, 1'b1, 32'hCAFE_F00D, 4'hF, 1'b1, 32'h0,        4'd0, 32'hDEAD_5678, 1'b1, 32'hCAFE_F00D};
        vecs[6]  = '{32'h0000_1000, 1'b1, 32'hFFFF_FFFF, 4'h7, 1'b1, 32'h0,        4'd0, 32'hCAFE_F00D, 1'b0, 32'h0};
        vecs[7]  = '{32'h0000_1000, 1'b0, 32'h0,        4'hF, 1'b1, 32'h0,        4'd0, 32'hCAFE_F00D, 1'b0, 32'h0};
        vecs[8]  = '{32'h0000_2000, 1'b0, 32'h0,        4'hF, 1'b0, 32'h1111_2222, 4'd3, 32'h1111_2222, 1'b0, 32'h0};
        vecs[9]  = '{32'h0000_1000, 1'b0, 32'h0,        4'hF, 1'b0, 32'h3333_4444, 4'd0, 32'h3333_4444, 1'b0, 32'h0};
        vecs[10] = '{32'h0000_2000, 1'b0, 32'h0,        4'hF, 1'b0, 32'h5555_6666, 4'd1, 32'h5555_6666, 1'b0, 32'h0};
        vecs[11] = '{32'h0000_0004, 1'b1, 32'h0000_00AB, 4'h1, 1'b0, 32'h0102_0304, 4'd2, 32'h0102_0304, 1'b1, 32'h0102_03AB};
        vecs[12] = '{32'h0000_0004, 1'b0, 32'h0,        4'hF, 1'b1, 32'h0,        4'd0, 32'h0102_03AB, 1'b0, 32'h0};
        vecs[13] = '{32'hFFFF_FFFC, 1'b0, 32'h0,        4'hF, 1'b0, 32'hA5A5_A5A5, 4'd2, 32'hA5A5_A5A5, 1'b0, 32'h0};
        vecs[14] = '{32'hFFFF_FFFF, 1'b0, 32'h0,        4'hF, 1'b1, 32'h0,        4'd0, 32'hA5A5_A5A5, 1'b0, 32'h0};
        vecs[15] = '{32'hFFFF_FFFC, 1'b1, 32'h1234_5678, 4'h0, 1'b1, 32'h0,        4'd0, 32'hA5A5_A5A5, 1'b0, 32'h0};
        vecs[16] = '{32'hFFFF_FFFC, 1'b0, 32'h0,        4'hF, 1'b1, 32'h0,        4'd0, 32'hA5A5_A5A5, 1'b0, 32'h0};
        // After a reset taken in MEM_WAIT, previously valid lines must miss.
        post[0]  = '{32'h0000_0004, 1'b0, 32'h0,        4'hF, 1'b0, 32'h0BAD_F00D, 4'd1, 32'h0BAD_F00D, 1'b0, 32'h0};
        post[1]  = '{32'h0000_3000, 1'b0, 32'h0,        4'hF, 1'b0, 32'h1357_2468, 4'd0, 32'h1357_2468, 1'b0, 32'h0};

        rst = 1'b0; l2_req_i = 1'b0; addr_i = '0; wr_en_i = 1'b0; wr_data_i = '0;
        byte_en_i = '0; mem_rd_valid_i = 1'b0; mem_rd_data_i = '0;

        // Reset state
        repeat (3) step();
        chk("reset valid",       {31'd0, l3_cache_valid_o}, 32'd0);
        chk("reset data",        l3_cache_data_o, 32'd0);
        chk("reset mem_rd_en",   {31'd0, mem_rd_en_o}, 32'd0);
        chk("reset mem_wr_en",   {31'd0, mem_wr_en_o}, 32'd0);
        chk("reset mem_wr_data", mem_wr_data_o, 32'd0);
        chk_counts("reset");
        rst = 1'b1;
        step();
        chk("ready after reset", {31'd0, l3_ready_o}, 32'd1);

        foreach (vecs[i]) do_txn(vecs[i], $sformatf("v%0d", i));

        // Request held through a miss: second address accepted exactly once.
        l2_req_i = 1'b1; addr_i = 32'h0000_3000; wr_en_i = 1'b0; byte_en_i = 4'hF;
        step();
        addr_i = 32'h0000_0004;
        nvalid = 0; nrd = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (mem_rd_valid_i) mem_rd_valid_i = 1'b0;
            if (k == 1) begin
                chk("hold rd_en",      {31'd0, mem_rd_en_o}, 32'd1);
                chk("hold not ready",  {31'd0, l3_ready_o}, 32'd0);
            end
            if (k == 2) begin
                mem_rd_valid_i = 1'b1;
                mem_rd_data_i  = 32'h7777_8888;
            end
            if (k == 4) begin
                chk("hold first valid", {31'd0, l3_cache_valid_o}, 32'd1);
                chk("hold first data",  l3_cache_data_o, 32'h7777_8888);
                chk("hold first addr",  mem_addr_o, 32'h0000_3000);
                chk("hold ready",       {31'd0, l3_ready_o}, 32'd1);
            end
            if (k == 5) begin
                chk("hold accepted",    {31'd0, l3_ready_o}, 32'd0);
                l2_req_i = 1'b0;
            end
            if (k == 7) begin
                chk("hold second valid", {31'd0, l3_cache_valid_o}, 32'd1);
                chk("hold second data",  l3_cache_data_o, 32'h0102_03AB);
            end
            if (l3_cache_valid_o) nvalid++;
            if (mem_rd_en_o) nrd++;
        end
        chk("hold response count", nvalid, 32'd2);
        chk("hold rd count", nrd, 32'd1);
        exp_misses++; exp_hits++;
        chk_counts("hold");

        // Reset taken in MEM_WAIT, then a late memory return.
        l2_req_i = 1'b1; addr_i = 32'h0000_5000;
        step();
        l2_req_i = 1'b0;
        step();
        chk("rst-mw rd_en", {31'd0, mem_rd_en_o}, 32'd1);
        rst = 1'b0;
        step();
        chk("rst-mw valid in reset", {31'd0, l3_cache_valid_o}, 32'd0);
        chk("rst-mw rd_en in reset", {31'd0, mem_rd_en_o}, 32'd0);
        rst = 1'b1;
        mem_rd_valid_i = 1'b1;
        mem_rd_data_i  = 32'h9999_9999;
        step();
        mem_rd_valid_i = 1'b0;
        chk("rst-mw ready", {31'd0, l3_ready_o}, 32'd1);
        exp_hits = 0; exp_misses = 0;
        nvalid = 0; nwr = 0;
        for (int k = 0; k < 4; k++) begin
            if (l3_cache_valid_o) nvalid++;
            if (mem_wr_en_o) nwr++;
            step();
        end
        chk("rst-mw no response", nvalid, 32'd0);
        chk("rst-mw no write", nwr, 32'd0);
        chk_counts("rst-mw");

        foreach (post[i]) do_txn(post[i], $sformatf("post%0d", i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
